// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, MSB-first payload, optional even parity
// (macro SERIAL_FRAME_RX_PARITY_EN), one-cycle gap, valid/ready holding register.
module serial_frame_rx #(
  parameter int DATA_BITS = 40,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 si,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BC_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, GAP = 2'd3} state_t;

  // Even parity: payload plus parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3} state_t;
`endif

  state_t                 state_r;
  logic [BC_W-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r;

  logic                   commit_s;
  logic                   par_ok_s;
  logic [DATA_BITS-1:0]   payload_s;
  logic                   load_s;
  logic                   drop_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic                   perr_s;
`endif

  // Commit decode: which edge completes a frame and what happens to it.
  always_comb begin
    commit_s  = 1'b0;
    par_ok_s  = 1'b1;
    payload_s = {DATA_BITS{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_EN
    payload_s = shift_r;
    if (state_r == PAR) begin
      commit_s = 1'b1;
      par_ok_s = even_parity_ok(shift_r, si);
    end else begin
      commit_s = 1'b0;
      par_ok_s = 1'b1;
    end
    perr_s = commit_s && !par_ok_s;
`else
    // The last data bit is taken straight from the line on the commit edge.
    payload_s = {shift_r[DATA_BITS-2:0], si};
    if ((state_r == SHIFT) && (bit_cnt_r == LAST_BIT)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
`endif
    if (commit_s && par_ok_s) begin
      load_s = !out_valid || out_ready;
      drop_s = out_valid && !out_ready;
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Frame FSM, holding register, counter and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BC_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      out_data  <= {DATA_BITS{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= {CNT_W{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= drop_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err <= perr_s;
`endif
      if (load_s) begin
        out_data  <= payload_s;
        frame_cnt <= frame_cnt + CNT_W'(1);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (si) begin
            bit_cnt_r <= {BC_W{1'b0}};
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          shift_r   <= {shift_r[DATA_BITS-2:0], si};
          bit_cnt_r <= bit_cnt_r + BC_W'(1);
          if (bit_cnt_r == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_r <= PAR;
`else
            state_r <= GAP;
`endif
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PAR:     state_r <= GAP;
`endif
        GAP:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef SERIAL_FRAME_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (default build, DATA_BITS=40); a second
// instance with CNT_W=2 shares the line and checks counter wrap.
module tb_serial_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        si = 1'b0;
  logic        out_ready = 1'b0;
  logic [39:0] out_data;
  logic        out_valid;
  logic        overrun;
  logic        parity_err;
  logic [15:0] frame_cnt;
  logic [39:0] out_data2;
  logic        out_valid2;
  logic        overrun2;
  logic        parity_err2;
  logic [1:0]  frame_cnt2;

  serial_frame_rx #(.DATA_BITS(40), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .si(si), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .parity_err(parity_err), .frame_cnt(frame_cnt)
  );

  serial_frame_rx #(.DATA_BITS(40), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .si(si), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready), .overrun(overrun2), .parity_err(parity_err2), .frame_cnt(frame_cnt2)
  );

  typedef struct {
    bit          kind;  // 0: frame presented, 1: overrun pulse
    logic [39:0] data;
    logic [15:0] cnt;
    int          cyc;
  } ev_t;

  ev_t  q[$];
  int   applied = 0;
  int   miscomp = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new frame is on the output when valid rises or reloads right after a handshake.
  ev_t         e;
  logic        new_s;
  logic        prev_valid = 1'b0;
  logic        hs_prev = 1'b0;
  logic [39:0] held = 40'h0;
  always @(negedge clk) begin
    if (!rst) begin
      new_s = out_valid && (!prev_valid || hs_prev);
      if (new_s || overrun) begin
        if (q.size() == 0) begin
          check("unexpected_output", {62'h0, overrun, out_valid}, 64'h0);
        end else begin
          e = q.pop_front();
          check("event_kind", {63'h0, overrun}, {63'h0, e.kind});
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          if (!e.kind) begin
            check("out_data", {24'h0, out_data}, {24'h0, e.data});
            check("frame_cnt", {48'h0, frame_cnt}, {48'h0, e.cnt});
            check("frame_cnt_w2", {62'h0, frame_cnt2}, {62'h0, e.cnt[1:0]});
            held = e.data;
          end
        end
      end else if (out_valid && prev_valid) begin
        check("hold_data", {24'h0, out_data}, {24'h0, held});
      end
      if (parity_err !== 1'b0) check("parity_err", {63'h0, parity_err}, 64'h0);
    end
    prev_valid = out_valid;
    hs_prev    = out_valid && out_ready;
  end

  task automatic send_frame(input logic [39:0] d, input bit exp_kind,
                            input logic [15:0] exp_cnt, input bit ready_on_commit);
    ev_t ev;
    @(posedge clk); #1;
    si = 1'b1;
    ev.kind = exp_kind; ev.data = d; ev.cnt = exp_cnt; ev.cyc = cyc + 41;
    q.push_back(ev);
    for (int i = 39; i >= 0; i--) begin
      @(posedge clk); #1;
      si = d[i];
      if (i == 0 && ready_on_commit) out_ready = 1'b1;
    end
    @(posedge clk); #1;
    si = 1'b0;
    if (ready_on_commit) out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; si = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] part;
    logic [39:0] vecs[5];
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_data", {24'h0, out_data}, 64'h0);
    check("rst_frame_cnt", {48'h0, frame_cnt}, 64'h0);
    check("rst_overrun", {63'h0, overrun}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Single frame, consumer always ready
    out_ready = 1'b1;
    send_frame(40'hA9F0AAAAA9, 1'b0, 16'd1, 1'b0);
    idle(3);
    check("valid_cleared", {63'h0, out_valid}, 64'h0);

    // Back-to-back with stalled consumer, then consume on a commit edge
    do_reset();
    out_ready = 1'b0;
    send_frame(40'h0000000001, 1'b0, 16'd1, 1'b0);
    send_frame(40'hFFFFFFFFFE, 1'b1, 16'd0, 1'b0);
    idle(2);
    check("held_after_overrun", {24'h0, out_data}, 64'h0000000001);
    send_frame(40'hFFFFFFFFFE, 1'b0, 16'd2, 1'b1);
    idle(2);
    check("valid_held", {63'h0, out_valid}, 64'h1);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("valid_consumed", {63'h0, out_valid}, 64'h0);

    // Reset mid-frame aborts it silently
    do_reset();
    out_ready = 1'b1;
    part = 40'h5A5A5A5A5A;
    @(posedge clk); #1 si = 1'b1;
    for (int i = 39; i >= 20; i--) begin
      @(posedge clk); #1 si = part[i];
    end
    @(posedge clk); #1 rst = 1'b1; si = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    send_frame(40'h123456789A, 1'b0, 16'd1, 1'b0);
    idle(3);

    // Counter wrap on the 2-bit instance
    do_reset();
    out_ready = 1'b1;
    vecs[0] = 40'h0102030405; vecs[1] = 40'h8000000000; vecs[2] = 40'hFFFFFFFFFF;
    vecs[3] = 40'h00000000FF; vecs[4] = 40'hC3C3C3C3C3;
    for (int k = 0; k < 5; k++) send_frame(vecs[k], 1'b0, 16'(k + 1), 1'b0);
    idle(5);

    check("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
